// File: rtl/filterbank_sequencer.sv
// filterbank_sequencer: sample intake, windowing and matrixing control for the
// polyphase analysis filterbank. Drives sample RAM, coefficient ROMs, Y buffer
// and a shared external MAC; the datapath itself lives outside this block.
module filterbank_sequencer #(
  parameter int unsigned MAC_LAT = 3,
  parameter int unsigned BLOCK   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sample,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        sram_we,
  output logic [8:0]  sram_waddr,
  output logic [15:0] sram_wdata,
  output logic [8:0]  sram_raddr,
  output logic [8:0]  coef_addr,
  output logic [5:0]  y_raddr,
  output logic [10:0] cos_addr,
  output logic        mac_en,
  output logic        mac_clear,
  output logic        mac_src,
  output logic        y_we,
  output logic [5:0]  y_waddr,
  output logic        sb_valid,
  output logic [4:0]  sb_idx,
  output logic        busy,
  output logic        block_done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WIN       = 3'd1;
  localparam logic [2:0] S_WIN_DRAIN = 3'd2;
  localparam logic [2:0] S_MAT       = 3'd3;
  localparam logic [2:0] S_MAT_DRAIN = 3'd4;

  localparam int unsigned      FW      = $clog2(BLOCK + 1);
  localparam int unsigned      DW      = $clog2(MAC_LAT + 1);
  localparam logic [FW-1:0]    BLOCK_F = FW'(BLOCK);
  localparam logic [DW-1:0]    DLAST   = DW'(MAC_LAT - 1);

  logic [2:0]    state, state_nxt;
  logic [8:0]    wp;
  logic [8:0]    base;
  logic [FW-1:0] fill, fill_nxt;
  logic [5:0]    k;
  logic [2:0]    j;
  logic [4:0]    i;
  logic [DW-1:0] dcnt;
  logic          start_run;
  logic          accept;
  logic          ready_nxt;

  // Writeback delay line: last-term flags and sum index, MAC_LAT deep.
  logic [MAC_LAT-1:0] wb_win;
  logic [MAC_LAT-1:0] wb_mat;
  logic [5:0]         wb_idx [MAC_LAT];
  logic               win_last;
  logic               mat_last;
  logic [5:0]         last_idx;

  assign accept   = sample_valid && sample_ready;
  assign busy     = (state != S_IDLE);
  assign win_last = (state == S_WIN) && (j == '1);
  assign mat_last = (state == S_MAT) && (k == '1);
  assign last_idx = (state == S_WIN) ? k : {1'b0, i};

  // Next state; a run starts from IDLE or straight out of MAT_DRAIN once a block is buffered.
  always_comb begin
    state_nxt = state;
    start_run = 1'b0;
    case (state)
      S_IDLE: begin
        if (fill == BLOCK_F) begin
          state_nxt = S_WIN;
          start_run = 1'b1;
        end
      end
      S_WIN:       if (k == '1 && j == '1) state_nxt = S_WIN_DRAIN;
      S_WIN_DRAIN: if (dcnt == DLAST) state_nxt = S_MAT;
      S_MAT:       if (i == '1 && k == '1) state_nxt = S_MAT_DRAIN;
      S_MAT_DRAIN: begin
        if (dcnt == DLAST) begin
          if (fill == BLOCK_F) begin
            state_nxt = S_WIN;
            start_run = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Ready is registered from next-cycle state so it reads 0 while in reset.
  always_comb begin
    fill_nxt  = start_run ? '0 : fill + FW'(accept);
    ready_nxt = (fill_nxt < BLOCK_F) && (state_nxt != S_WIN) && (state_nxt != S_WIN_DRAIN);
  end

  // State, intake pointers, loop counters and registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      wp           <= '0;
      base         <= '0;
      fill         <= '0;
      k            <= '0;
      j            <= '0;
      i            <= '0;
      dcnt         <= '0;
      sample_ready <= 1'b0;
      sram_we      <= 1'b0;
      sram_waddr   <= '0;
      sram_wdata   <= '0;
      block_done   <= 1'b0;
    end else begin
      state        <= state_nxt;
      fill         <= fill_nxt;
      sample_ready <= ready_nxt;
      sram_we      <= accept;
      block_done   <= (state == S_MAT_DRAIN) && (dcnt == DLAST);
      if (accept) begin
        wp         <= wp + 9'd1;
        sram_waddr <= wp;
        sram_wdata <= sample;
      end
      if (start_run) base <= wp;
      // Counters wrap back to zero on the final step, so each pass starts clean.
      case (state)
        S_WIN: begin
          j <= j + 3'd1;
          if (j == '1) k <= k + 6'd1;
        end
        S_MAT: begin
          k <= k + 6'd1;
          if (k == '1) i <= i + 5'd1;
        end
        S_WIN_DRAIN, S_MAT_DRAIN: dcnt <= (dcnt == DLAST) ? '0 : dcnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Writeback delay line; keeps shifting through the drain states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_win <= '0;
      wb_mat <= '0;
      for (int unsigned n = 0; n < MAC_LAT; n++) wb_idx[n] <= '0;
    end else begin
      wb_win[0] <= win_last;
      wb_mat[0] <= mat_last;
      wb_idx[0] <= last_idx;
      for (int unsigned n = 1; n < MAC_LAT; n++) begin
        wb_win[n] <= wb_win[n-1];
        wb_mat[n] <= wb_mat[n-1];
        wb_idx[n] <= wb_idx[n-1];
      end
    end
  end

  // Writeback strobes at the tail of the delay line; indices forced to 0 when idle.
  always_comb begin
    y_we     = wb_win[MAC_LAT-1];
    sb_valid = wb_mat[MAC_LAT-1];
    y_waddr  = y_we ? wb_idx[MAC_LAT-1] : '0;
    sb_idx   = sb_valid ? wb_idx[MAC_LAT-1][4:0] : '0;
  end

  // MAC step addressing; every field is 0 outside the two compute passes.
  always_comb begin
    mac_en     = 1'b0;
    mac_src    = 1'b0;
    mac_clear  = 1'b0;
    sram_raddr = '0;
    coef_addr  = '0;
    y_raddr    = '0;
    cos_addr   = '0;
    case (state)
      S_WIN: begin
        mac_en     = 1'b1;
        mac_clear  = (j == '0);
        coef_addr  = {j, k};
        sram_raddr = base - 9'd1 - {j, k};
      end
      S_MAT: begin
        mac_en    = 1'b1;
        mac_src   = 1'b1;
        mac_clear = (k == '0);
        y_raddr   = k;
        cos_addr  = {i, k};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_filterbank_sequencer.sv
// Scoreboard bench for filterbank_sequencer: stimulus pushes expected writes and
// per-cycle run vectors; a negedge monitor pops and compares.
module tb_filterbank_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic        sram_we;
  logic [8:0]  sram_waddr;
  logic [15:0] sram_wdata;
  logic [8:0]  sram_raddr;
  logic [8:0]  coef_addr;
  logic [5:0]  y_raddr;
  logic [10:0] cos_addr;
  logic        mac_en;
  logic        mac_clear;
  logic        mac_src;
  logic        y_we;
  logic [5:0]  y_waddr;
  logic        sb_valid;
  logic [4:0]  sb_idx;
  logic        busy;
  logic        block_done;

  always #5 clk = ~clk;

  filterbank_sequencer #(.MAC_LAT(3), .BLOCK(32)) dut (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .sram_we(sram_we), .sram_waddr(sram_waddr),
    .sram_wdata(sram_wdata), .sram_raddr(sram_raddr), .coef_addr(coef_addr),
    .y_raddr(y_raddr), .cos_addr(cos_addr), .mac_en(mac_en), .mac_clear(mac_clear),
    .mac_src(mac_src), .y_we(y_we), .y_waddr(y_waddr), .sb_valid(sb_valid),
    .sb_idx(sb_idx), .busy(busy), .block_done(block_done)
  );

  typedef struct packed {
    logic        mac_en;
    logic        mac_src;
    logic        mac_clear;
    logic [8:0]  sram_raddr;
    logic [8:0]  coef_addr;
    logic [5:0]  y_raddr;
    logic [10:0] cos_addr;
    logic        y_we;
    logic [5:0]  y_waddr;
    logic        sb_valid;
    logic [4:0]  sb_idx;
    logic        busy;
  } obs_t;

  typedef struct {
    obs_t o;
    bit   win;
    bit   last;
    bit   cont;
    bit   from_idle;
  } vec_t;

  typedef struct packed {
    logic [8:0]  a;
    logic [15:0] d;
  } wr_t;

  obs_t  act;
  logic [79:0] all_out;
  assign act = {mac_en, mac_src, mac_clear, sram_raddr, coef_addr, y_raddr, cos_addr,
                y_we, y_waddr, sb_valid, sb_idx, busy};
  assign all_out = {sample_ready, sram_we, sram_waddr, sram_wdata, sram_raddr, coef_addr,
                    y_raddr, cos_addr, mac_en, mac_clear, mac_src, y_we, y_waddr,
                    sb_valid, sb_idx, busy, block_done};

  vec_t cq[$];
  wr_t  wq[$];
  int   errors = 0;
  int   checks = 0;
  int   runs_done = 0;
  logic [8:0] wp_m = '0;
  int   n_tot = 0;

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  function automatic logic [15:0] dat(input int n);
    return 16'(n * 1237) ^ 16'h8001;
  endfunction

  // Expected per-cycle outputs of one run: WIN 512, WIN_DRAIN 3, MAT 2048, MAT_DRAIN 3.
  task automatic push_run(input logic [8:0] b, input bit cont, input bit from_idle);
    vec_t v;
    int   kk, jj, m;
    logic [8:0] t;
    for (int c = 0; c < 2566; c++) begin
      v.o = '0;
      v.o.busy = 1'b1;
      v.win = 1'b0;
      v.last = (c == 2565);
      v.cont = cont && (c == 0);
      v.from_idle = from_idle && (c == 0);
      if (c < 512) begin
        kk = c / 8;
        jj = c % 8;
        t = 9'(kk + 64 * jj);
        v.o.mac_en = 1'b1;
        v.o.mac_clear = (jj == 0);
        v.o.sram_raddr = b - 9'd1 - t;
        v.o.coef_addr = t;
        v.win = 1'b1;
      end else if (c < 515) begin
        v.win = 1'b1;
      end else if (c < 2563) begin
        m = c - 515;
        v.o.mac_en = 1'b1;
        v.o.mac_src = 1'b1;
        v.o.mac_clear = (m % 64 == 0);
        v.o.y_raddr = 6'(m % 64);
        v.o.cos_addr = 11'(m);
      end
      if (c >= 3 && c < 515 && (c - 3) % 8 == 7) begin
        v.o.y_we = 1'b1;
        v.o.y_waddr = 6'((c - 3) / 8);
      end
      if (c >= 518 && (c - 518) % 64 == 63) begin
        v.o.sb_valid = 1'b1;
        v.o.sb_idx = 5'((c - 518) / 64);
      end
      cq.push_back(v);
    end
  endtask

  // Monitor: write strobes, run vectors, block_done pulse, quiet idle.
  bit   in_run = 0;
  bit   exp_done = 0;
  int   since_we = 1000;
  vec_t mv;
  wr_t  mw;
  always @(negedge clk) begin
    if (!rst) begin
      in_run = 0;
      exp_done = 0;
      since_we = 1000;
    end else begin
      if (exp_done || block_done) begin
        chk("block_done", 96'(block_done), 96'(exp_done));
        if (exp_done && block_done) runs_done++;
      end
      exp_done = 0;
      if (sram_we) begin
        if (wq.size() == 0) chk("sram_we_unexpected", 96'(1), 96'(0));
        else begin
          mw = wq.pop_front();
          chk("sram_write", {sram_waddr, sram_wdata}, {mw.a, mw.d});
        end
      end
      if (!in_run && cq.size() > 0 && busy) begin
        in_run = 1;
        if (cq[0].from_idle) chk("win_start_latency", 96'(since_we), 96'(1));
      end
      if (in_run && cq.size() == 0) begin
        chk("run_vectors_exhausted", 96'(1), 96'(0));
        in_run = 0;
      end else if (in_run) begin
        mv = cq.pop_front();
        chk("step", 96'(act), 96'(mv.o));
        if (mv.win) chk("ready_low_in_win", 96'(sample_ready), 96'(0));
        if (mv.last) begin
          exp_done = 1;
          in_run = (cq.size() > 0) && cq[0].cont;
        end
      end else begin
        chk("idle_quiet", 96'({busy, mac_en, y_we, sb_valid}), 96'(0));
      end
      since_we = sram_we ? 1 : since_we + 1;
    end
  end

  task automatic feed_spaced(input int n);
    wr_t w;
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      sample = dat(n_tot);
      sample_valid = 1'b1;
      chk("ready_while_feeding", 96'(sample_ready), 96'(1));
      w.a = wp_m;
      w.d = sample;
      wq.push_back(w);
      wp_m++;
      n_tot++;
      @(negedge clk);
      sample_valid = 1'b0;
    end
  endtask

  // Valid held high; every 32nd accept schedules a run (back-to-back after the first).
  task automatic hold_feed(input int n);
    wr_t w;
    int  got = 0;
    int  g = 0;
    while (got < n && g < 60000) begin
      @(negedge clk);
      g++;
      sample = dat(n_tot);
      sample_valid = 1'b1;
      if (sample_ready) begin
        w.a = wp_m;
        w.d = sample;
        wq.push_back(w);
        wp_m++;
        n_tot++;
        got++;
        if (got % 32 == 0) push_run(wp_m, got > 32, got == 32);
      end
    end
    if (got < n) chk("hold_feed_timeout", 96'(got), 96'(n));
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_runs(input int target, input int budget);
    int g = 0;
    while (runs_done < target && g < budget) begin
      @(negedge clk);
      g++;
    end
    chk("runs_completed", 96'(runs_done), 96'(target));
  endtask

  initial begin
    int g;
    rst = 1'b0;
    sample = '0;
    sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", 96'(all_out), 96'(0));
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);

    // First block, one sample every 2 cycles: waddr 0..31, run with base 32.
    feed_spaced(32);
    push_run(9'd32, 1'b0, 1'b1);
    wait_runs(1, 4000);

    // Continuous valid: 15 more blocks, back-to-back runs, base ends at 0.
    hold_feed(480);
    wait_runs(16, 6000);

    // Write pointer wraps to 0; abort this run at MAT step 1000.
    feed_spaced(32);
    push_run(9'd32, 1'b0, 1'b1);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!busy && g < 200);
    chk("run_started_before_reset", 96'(busy), 96'(1));
    repeat (1515) @(posedge clk);
    #1 chk("cos_addr_at_mat_step_1000", 96'(cos_addr), 96'(1000));
    #1 rst = 1'b0;
    cq.delete();
    wq.delete();
    #1 chk("async_reset_outputs", 96'(all_out), 96'(0));
    repeat (3) @(posedge clk);
    #1 chk("outputs_held_in_reset", 96'(all_out), 96'(0));
    @(posedge clk);
    #2 rst = 1'b1;
    wp_m = '0;
    repeat (2) @(negedge clk);

    // Restart after reset: waddr 0..31 again, full run with base 32.
    feed_spaced(32);
    push_run(9'd32, 1'b0, 1'b1);
    wait_runs(17, 4000);
    repeat (10) @(negedge clk);
    chk("queues_drained", 96'(cq.size() + wq.size()), 96'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
